uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 enable  input  1  global UART enable.
REQ-005 tx_enable  input  1  transmitter enable.
REQ-006 parity_enable  input  1  1 = append a parity bit.
REQ-007 parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-008 data_len_7bit  input  1  1 = 7 data bits, 0 = 8 data bits.
REQ-009 stop_2  input  1  1 = two stop bits, 0 = one stop bit.
REQ-010 osr_tick  input  1  one-cycle oversample strobe.
REQ-011 osr_value  input  8  oversample ticks per bit; 0 is treated as 1.
REQ-012 data_in  input  8  byte to send; bit 7 is ignored in 7-bit mode.
REQ-013 data_valid  input  1  request to send data_in.
REQ-014 data_ready  output  1  high when a frame can be accepted.
REQ-015 txd  output  1  serial line; registered; idle level 1.
REQ-016 tx_done  output  1  one-cycle pulse when a frame completes.
REQ-017 busy  output  1  high while the state is not IDLE.

Function
REQ-018 SHALL use the states IDLE, START, DATA, PARITY and STOP.
REQ-019 data_ready SHALL equal (state==IDLE) && enable && tx_enable; it is combinational.
REQ-020 A frame SHALL be accepted in the cycle where data_valid && data_ready.
- At accept: latch data_in, data_len_7bit, parity_enable, parity_odd, stop_2 and osr_value.
- Changes to these inputs mid-frame have no effect.
REQ-021 In the cycle after accept: state=START, txd=0, and the bit counter is loaded with osr_value-1.
REQ-022 Bit timing: each bit lasts exactly N osr_tick strobes (N = latched osr_value, min 1).
- Counter decrements on osr_tick.
- On osr_tick with counter==0: advance to the next bit and reload N-1.
REQ-023 DATA SHALL send the data bits LSB first, 7 or 8 bits, and keep a running XOR.
REQ-024 After the last data bit, the next state SHALL be PARITY if parity is enabled, else STOP.
REQ-025 The parity bit SHALL be XOR(sent bits) for even parity, or its inverse for odd parity.
REQ-026 STOP SHALL drive txd=1 for one bit period, or two if stop_2 is set (tracked by stop_count).
REQ-027 At the end of the final stop period: state=IDLE, and tx_done=1 for exactly one cycle.
- data_ready rises in that same cycle (back-to-back frames have no idle gap beyond the handshake cycle).
REQ-028 If enable or tx_enable deasserts mid-frame, the next cycle SHALL be state=IDLE with txd=1, no tx_done, and counters cleared.
REQ-029 osr_tick while IDLE SHALL have no effect; data_valid while not ready SHALL be ignored and never queued.
REQ-030 Frame length in ticks SHALL be N*(1+D+P+S), where D = 7 or 8, P = 0 or 1, S = 1 or 2.

Reset
REQ-031 Reset values SHALL be: state=IDLE, txd=1, tx_done=0, busy=0, all counters 0, and the data shift register 0.
REQ-032 data_ready SHALL be 0 during reset and follow REQ-019 afterwards.

Structure
REQ-033 The shared package uart_pkg SHALL hold:
- the frame state enum uart_state_t (IDLE, START, DATA, PARITY, STOP);
- the constant UART_IDLE_LEVEL=1'b1.
REQ-034 uart_tx SHALL be a single module with no sub-modules; the bit-period counter is inline.

Verification
REQ-035 8N1, osr_value=16, osr_tick every cycle, send 0x55: txd = 0,1,0,1,0,1,0,1,0,1, each bit 16 cycles; tx_done pulses once 160 ticks after start.
REQ-036 7E1, send 0x41: data bits 1,0,0,0,0,0,1 then parity 0; send 0x43 in 7O1: parity 0; 8E1, send 0x01: parity 1.
REQ-037 8N2, osr_value=4: the stop level is held for 8 ticks; frame length is 44 ticks.
REQ-038 Clear tx_enable during DATA bit 3: txd=1 and busy=0 on the next cycle, and no tx_done.
REQ-039 Hold data_valid with 0xA5 then 0x3C back-to-back: the second accept occurs in the tx_done cycle, and the second start bit follows in the next cycle.
REQ-040 Change osr_value from 16 to 8 mid-frame: the current frame keeps 16-tick bits, and the next frame uses 8.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and line idle level.
package uart_pkg;

    localparam int unsigned UART_STATE_W = 3;

    typedef enum logic [UART_STATE_W-1:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 7/8 data bits LSB first, optional parity, 1/2 stop bits,
// each bit lasting a programmable number of oversample strobes.
module uart_tx
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       tx_enable,
    input  logic       parity_enable,
    input  logic       parity_odd,
    input  logic       data_len_7bit,
    input  logic       stop_2,
    input  logic       osr_tick,
    input  logic [7:0] osr_value,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       txd,
    output logic       tx_done,
    output logic       busy
);

    localparam int unsigned OSR_W  = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;

    uart_state_t        state_q, state_d;
    logic [OSR_W-1:0]   cnt_q, cnt_d;
    logic [OSR_W-1:0]   reload_q, reload_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               par_q, par_d;
    logic               len7_q, len7_d;
    logic               par_en_q, par_en_d;
    logic               par_odd_q, par_odd_d;
    logic               stop2_q, stop2_d;
    logic               stop_cnt_q, stop_cnt_d;
    logic               txd_q, txd_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               run;
    logic               bit_end;
    logic [IDX_W-1:0]   last_idx;

    assign run        = enable && tx_enable;
    assign data_ready = rst_n && (state_q == IDLE) && run;
    assign txd        = txd_q;
    assign tx_done    = done_q;
    assign busy       = busy_q;

    assign bit_end  = osr_tick && (cnt_q == '0);
    assign last_idx = len7_q ? IDX_W'(6) : IDX_W'(7);

    // Next-state, bit timing and serial output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        reload_d   = reload_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        len7_d     = len7_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        txd_d      = txd_q;
        done_d     = 1'b0;

        if (state_q != IDLE && osr_tick) begin
            cnt_d = (cnt_q == '0) ? reload_q : cnt_q - OSR_W'(1);
        end

        case (state_q)
            IDLE: begin
                txd_d = UART_IDLE_LEVEL;
                if (data_valid && data_ready) begin
                    state_d    = START;
                    txd_d      = 1'b0;
                    shift_d    = data_in;
                    len7_d     = data_len_7bit;
                    par_en_d   = parity_enable;
                    par_odd_d  = parity_odd;
                    stop2_d    = stop_2;
                    reload_d   = (osr_value == '0) ? '0 : osr_value - OSR_W'(1);
                    cnt_d      = (osr_value == '0) ? '0 : osr_value - OSR_W'(1);
                    idx_d      = '0;
                    par_d      = 1'b0;
                    stop_cnt_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    if (idx_q == last_idx) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            txd_d   = par_q ^ shift_q[0] ^ par_odd_q;
                        end else begin
                            state_d    = STOP;
                            txd_d      = UART_IDLE_LEVEL;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        txd_d = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    txd_d      = UART_IDLE_LEVEL;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        done_d     = 1'b1;
                        txd_d      = UART_IDLE_LEVEL;
                        cnt_d      = '0;
                        idx_d      = '0;
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = UART_IDLE_LEVEL;
            end
        endcase

        // Losing either enable abandons the frame immediately.
        if (state_q != IDLE && !run) begin
            state_d    = IDLE;
            txd_d      = UART_IDLE_LEVEL;
            done_d     = 1'b0;
            cnt_d      = '0;
            idx_d      = '0;
            stop_cnt_d = 1'b0;
            par_d      = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            reload_q   <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            len7_q     <= 1'b0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            txd_q      <= UART_IDLE_LEVEL;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reload_q   <= reload_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            len7_q     <= len7_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

endmodule
